// File: rtl/c3lib_ckinv_pol_ctl_if.sv
// Polarity request handshake between a requester and the clock polarity sequencer.
interface c3lib_ckinv_pol_ctl_if;
  logic pol_req_vld;
  logic pol_req_inv;
  logic pol_req_rdy;
  logic pol_done;

  modport master (
    output pol_req_vld,
    output pol_req_inv,
    input  pol_req_rdy,
    input  pol_done
  );

  modport slave (
    input  pol_req_vld,
    input  pol_req_inv,
    output pol_req_rdy,
    output pol_done
  );
endinterface

// File: rtl/c3lib_ckinv_pol_ctl.sv
// Glitch-free polarity sequencer for a hardened clock path: gate off, flip the
// inverter select, re-enable, then pulse done. All outputs are registered.
module c3lib_ckinv_pol_ctl #(
  parameter int       GATE_WAIT = 4,
  parameter int       SEL_WAIT  = 4,
  parameter int       CNT_W     = 4,
  parameter bit       INIT_INV  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  c3lib_ckinv_pol_ctl_if.slave    req,
  output logic                    ck_en,
  output logic                    ck_inv_sel,
  output logic                    busy
);

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_GATE_OFF = 3'd2,
    ST_SWITCH   = 3'd3,
    ST_UNGATE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(SEL_WAIT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             target;

  // Outputs are computed together with the next state so that each one takes
  // its new value in the very first cycle of the state it belongs to; the
  // select only ever moves on the GATE_OFF -> SWITCH edge, while ck_en is 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_START;
      cnt             <= '0;
      target          <= INIT_INV;
      ck_en           <= 1'b0;
      ck_inv_sel      <= INIT_INV;
      req.pol_req_rdy <= 1'b0;
      req.pol_done    <= 1'b0;
      busy            <= 1'b1;
    end else begin
      req.pol_done <= 1'b0;
      case (state)
        ST_START: begin
          if (cnt == GATE_LAST) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            ck_en           <= 1'b1;
            req.pol_req_rdy <= 1'b1;
            busy            <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (req.pol_req_vld) begin
            if (req.pol_req_inv == ck_inv_sel) begin
              req.pol_done <= 1'b1;
            end else begin
              state           <= ST_GATE_OFF;
              cnt             <= '0;
              target          <= req.pol_req_inv;
              ck_en           <= 1'b0;
              req.pol_req_rdy <= 1'b0;
              busy            <= 1'b1;
            end
          end
        end
        ST_GATE_OFF: begin
          if (cnt == GATE_LAST) begin
            state      <= ST_SWITCH;
            cnt        <= '0;
            ck_inv_sel <= target;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SWITCH: begin
          if (cnt == SEL_LAST) begin
            state <= ST_UNGATE;
            cnt   <= '0;
            ck_en <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_UNGATE: begin
          if (cnt == GATE_LAST) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            req.pol_req_rdy <= 1'b1;
            req.pol_done    <= 1'b1;
            busy            <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state           <= ST_START;
          cnt             <= '0;
          ck_en           <= 1'b0;
          req.pol_req_rdy <= 1'b0;
          busy            <= 1'b1;
        end
      endcase
    end
  end

endmodule
